// File: rtl/ddr_fifo_pkg.sv
// ddr_fifo_pkg: shared helpers for the DDR write-path pack FIFO.
package ddr_fifo_pkg;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Number of narrow lanes packed into one wide word.
    function automatic int pack_ratio(input int out_w, input int in_w);
        return out_w / in_w;
    endfunction

    // Lane counter width; at least one bit even for tiny ratios.
    function automatic int lane_w(input int ratio);
        return (ratio > 1) ? clog2(ratio) : 1;
    endfunction

    // One keep bit per narrow lane.
    function automatic int keep_w(input int out_w, input int in_w);
        return pack_ratio(out_w, in_w);
    endfunction

endpackage

// File: rtl/ddr_fifo_sdp_ram.sv
// ddr_fifo_sdp_ram: simple dual-port RAM, one write port, registered read port.
module ddr_fifo_sdp_ram #(
    parameter int WIDTH  = 265,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [0:(1 << ADDR_W)-1];
    logic [WIDTH-1:0] rdata_q;

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ddr_wr_pack_fifo.sv
// ddr_wr_pack_fifo: packs narrow capture words into wide DDR words and presents
// them first-word-fall-through, with frame-end flush, lane masks and burst-ready.
module ddr_wr_pack_fifo
    import ddr_fifo_pkg::*;
#(
    parameter int  IN_WIDTH    = 32,
    parameter int  OUT_WIDTH   = 256,
    parameter int  DEPTH_WIDTH = 9,
    parameter int  BURST_LEN   = 16,
    localparam int RATIO       = pack_ratio(OUT_WIDTH, IN_WIDTH),
    localparam int KEEP_W      = keep_w(OUT_WIDTH, IN_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [IN_WIDTH-1:0]    wr_data,
    input  logic                   wr_last,
    output logic                   wr_vld,
    input  logic                   rd_en,
    output logic                   rd_vld,
    output logic [OUT_WIDTH-1:0]   rd_data,
    output logic [KEEP_W-1:0]      rd_keep,
    output logic                   rd_last,
    output logic                   burst_rdy,
    output logic [DEPTH_WIDTH:0]   rd_used,
    output logic                   overflow
);

    localparam int DEPTH  = 1 << DEPTH_WIDTH;
    localparam int LANE_W = lane_w(RATIO);
    localparam int PTR_W  = DEPTH_WIDTH + 1;
    localparam int MEM_W  = OUT_WIDTH + KEEP_W + 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]  DEPTH_C   = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0]  BURST_C   = PTR_W'(BURST_LEN);

    logic [OUT_WIDTH-1:0] pack_q, pack_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [PTR_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic                 commit_q, commit_d, commit_last_q, commit_last_d;
    logic                 ram_vld_q, ram_vld_d;
    logic                 rd_vld_q, rd_vld_d;
    logic [OUT_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [KEEP_W-1:0]    rd_keep_q, rd_keep_d;
    logic                 rd_last_q, rd_last_d;
    logic [PTR_W-1:0]     rd_used_q, rd_used_d, last_cnt_q, last_cnt_d;
    logic                 burst_rdy_q, burst_rdy_d;
    logic                 wr_vld_q, wr_vld_d;
    logic                 overflow_q, overflow_d;

    logic                 accept, commit, pop, out_load, ram_re, ram_avail, ram_full;
    logic [OUT_WIDTH-1:0] wr_word;
    logic [KEEP_W-1:0]    wr_keep;
    logic [MEM_W-1:0]     ram_wdata, ram_rdata;

    // Write side: place the word in its lane, commit on the last lane or frame end.
    always_comb begin
        accept  = wr_en && wr_vld_q;
        commit  = accept && ((lane_q == LAST_LANE) || wr_last);
        wr_word = pack_q;
        wr_word[int'(lane_q) * IN_WIDTH +: IN_WIDTH] = wr_data;
        wr_keep = '0;
        for (int i = 0; i < KEEP_W; i++) wr_keep[i] = (i <= int'(lane_q));
        pack_d        = pack_q;
        lane_d        = lane_q;
        if (accept) begin
            if (commit) begin
                // Unused upper lanes stay zero because the pack register is cleared here.
                pack_d = '0;
                lane_d = '0;
            end else begin
                pack_d = wr_word;
                lane_d = lane_q + LANE_ONE;
            end
        end
        wptr_d        = commit ? (wptr_q + PTR_ONE) : wptr_q;
        commit_d      = commit;
        commit_last_d = commit && wr_last;
        overflow_d    = overflow_q || (wr_en && !wr_vld_q);
        if (clear) begin
            pack_d        = '0;
            lane_d        = '0;
            wptr_d        = '0;
            commit_d      = 1'b0;
            commit_last_d = 1'b0;
            overflow_d    = 1'b0;
        end
    end

    assign ram_wdata = {wr_last, wr_keep, wr_word};

    // Read side: RAM read register feeds the output register so a pop refills both.
    always_comb begin
        pop       = rd_en && rd_vld_q;
        ram_avail = (wptr_q != rptr_q);
        out_load  = ram_vld_q && (!rd_vld_q || pop);
        ram_re    = ram_avail && (!ram_vld_q || out_load);
        rptr_d    = ram_re ? (rptr_q + PTR_ONE) : rptr_q;
        ram_vld_d = ram_re ? 1'b1 : (out_load ? 1'b0 : ram_vld_q);
        rd_vld_d  = out_load ? 1'b1 : (pop ? 1'b0 : rd_vld_q);
        rd_data_d = out_load ? ram_rdata[OUT_WIDTH-1:0]        : rd_data_q;
        rd_keep_d = out_load ? ram_rdata[OUT_WIDTH +: KEEP_W]  : rd_keep_q;
        rd_last_d = out_load ? ram_rdata[MEM_W-1]              : rd_last_q;

        // Occupancy trails the commit by one cycle; simultaneous add/remove cancels.
        rd_used_d = rd_used_q;
        if (commit_q && !pop)      rd_used_d = rd_used_q + PTR_ONE;
        else if (!commit_q && pop) rd_used_d = rd_used_q - PTR_ONE;

        last_cnt_d = last_cnt_q;
        if (commit_last_q && !(pop && rd_last_q))      last_cnt_d = last_cnt_q + PTR_ONE;
        else if (!commit_last_q && (pop && rd_last_q)) last_cnt_d = last_cnt_q - PTR_ONE;

        // A pending frame end releases a short tail even below a full burst.
        burst_rdy_d = (rd_used_d >= BURST_C) || (last_cnt_d != '0);
        wr_vld_d    = ((rd_used_d + (commit ? PTR_ONE : '0)) < DEPTH_C);

        if (clear) begin
            rptr_d      = '0;
            ram_vld_d   = 1'b0;
            rd_vld_d    = 1'b0;
            rd_data_d   = '0;
            rd_keep_d   = '0;
            rd_last_d   = 1'b0;
            rd_used_d   = '0;
            last_cnt_d  = '0;
            burst_rdy_d = 1'b0;
            wr_vld_d    = 1'b0;
        end
    end

    // State registers; async reset empties the FIFO and drops the partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_q        <= '0;
            lane_q        <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            commit_q      <= 1'b0;
            commit_last_q <= 1'b0;
            ram_vld_q     <= 1'b0;
            rd_vld_q      <= 1'b0;
            rd_data_q     <= '0;
            rd_keep_q     <= '0;
            rd_last_q     <= 1'b0;
            rd_used_q     <= '0;
            last_cnt_q    <= '0;
            burst_rdy_q   <= 1'b0;
            wr_vld_q      <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            pack_q        <= pack_d;
            lane_q        <= lane_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            commit_q      <= commit_d;
            commit_last_q <= commit_last_d;
            ram_vld_q     <= ram_vld_d;
            rd_vld_q      <= rd_vld_d;
            rd_data_q     <= rd_data_d;
            rd_keep_q     <= rd_keep_d;
            rd_last_q     <= rd_last_d;
            rd_used_q     <= rd_used_d;
            last_cnt_q    <= last_cnt_d;
            burst_rdy_q   <= burst_rdy_d;
            wr_vld_q      <= wr_vld_d;
            overflow_q    <= overflow_d;
        end
    end

    ddr_fifo_sdp_ram #(
        .WIDTH  (MEM_W),
        .ADDR_W (DEPTH_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (commit),
        .waddr (wptr_q[DEPTH_WIDTH-1:0]),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (rptr_q[DEPTH_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    // Same index with differing MSBs means the RAM holds DEPTH words.
    assign ram_full = (wptr_q[DEPTH_WIDTH] != rptr_q[DEPTH_WIDTH]) &&
                      (wptr_q[DEPTH_WIDTH-1:0] == rptr_q[DEPTH_WIDTH-1:0]);

    a_ratio_int:  assert property (@(posedge clk) (OUT_WIDTH % IN_WIDTH) == 0);
    a_burst_fit:  assert property (@(posedge clk) BURST_LEN <= DEPTH);
    a_used_bound: assert property (@(posedge clk) disable iff (rst) rd_used_q <= DEPTH_C);
    a_no_wr_full: assert property (@(posedge clk) disable iff (rst) ram_full |-> !commit);

    assign wr_vld    = wr_vld_q;
    assign rd_vld    = rd_vld_q;
    assign rd_data   = rd_data_q;
    assign rd_keep   = rd_keep_q;
    assign rd_last   = rd_last_q;
    assign burst_rdy = burst_rdy_q;
    assign rd_used   = rd_used_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ddr_wr_pack_fifo.sv
// tb_ddr_wr_pack_fifo: directed checks of packing, latency, capacity, burst and reset.
module tb_ddr_wr_pack_fifo;

    typedef logic [264:0] ent_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic         wr_en = 1'b0;
    logic [31:0]  wr_data = '0;
    logic         wr_last = 1'b0;
    logic         wr_vld;
    logic         rd_en = 1'b0;
    logic         rd_vld;
    logic [255:0] rd_data;
    logic [7:0]   rd_keep;
    logic         rd_last;
    logic         burst_rdy;
    logic [9:0]   rd_used;
    logic         overflow;

    int n_chk  = 0;
    int n_pass = 0;
    int n_stall = 0;

    ent_t         exp_q[$];
    logic [255:0] m_pack = '0;
    logic [7:0]   m_keep;
    int           m_lane = 0;

    ddr_wr_pack_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .wr_vld    (wr_vld),
        .rd_en     (rd_en),
        .rd_vld    (rd_vld),
        .rd_data   (rd_data),
        .rd_keep   (rd_keep),
        .rd_last   (rd_last),
        .burst_rdy (burst_rdy),
        .rd_used   (rd_used),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input ent_t got, input ent_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference packing: first word in the LSBs, commit on lane 7 or frame end.
    task automatic model_accept(input logic [31:0] d, input logic last);
        m_pack[m_lane*32 +: 32] = d;
        if (m_lane == 7 || last) begin
            m_keep = '0;
            for (int i = 0; i <= m_lane; i++) m_keep[i] = 1'b1;
            exp_q.push_back({last, m_keep, m_pack});
            m_pack = '0;
            m_lane = 0;
        end else begin
            m_lane++;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pack = '0;
        m_lane = 0;
    endtask

    task automatic push(input logic [31:0] d, input logic last);
        wr_en = 1'b1;
        wr_data = d;
        wr_last = last;
        if (wr_vld) model_accept(d, last);
        else n_stall++;
        step();
        wr_en = 1'b0;
        wr_last = 1'b0;
    endtask

    task automatic drain(input int n, input int budget);
        int   got = 0;
        int   cyc = 0;
        ent_t e;
        rd_en = 1'b1;
        while (got < n && cyc < budget) begin
            if (rd_vld) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                chk("drain_word", {rd_last, rd_keep, rd_data}, e);
                got++;
            end
            step();
            cyc++;
        end
        rd_en = 1'b0;
        if (got < n) chk("drain_timeout", ent_t'(got), ent_t'(n));
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_rd_vld", rd_vld, 0);
        chk("rst_rd_used", rd_used, 0);
        chk("rst_wr_vld", wr_vld, 0);
        chk("rst_burst", burst_rdy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", rd_data, 0);
        rst = 1'b0;
        chk("rel_wr_vld0", wr_vld, 0);
        step();
        chk("rel_wr_vld1", wr_vld, 1);

        // 8 full-lane words, no frame end
        for (int i = 1; i <= 8; i++) push(32'(i), 1'b0);
        chk("a_lat0", rd_vld, 0);
        step();
        chk("a_lat1", rd_vld, 0);
        chk("a_used", rd_used, 1);
        step();
        chk("a_vld", rd_vld, 1);
        chk("a_data", rd_data,
            256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        chk("a_keep", rd_keep, 8'hFF);
        chk("a_last", rd_last, 0);
        chk("a_burst", burst_rdy, 0);
        step();
        chk("a_hold", rd_data,
            256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        drain(1, 10);
        chk("a_empty", rd_vld, 0);

        // Short frame: 3 words, last on the third
        push(32'hA, 1'b0);
        push(32'hB, 1'b0);
        push(32'hC, 1'b1);
        step();
        chk("b_used", rd_used, 1);
        chk("b_burst", burst_rdy, 1);
        step();
        chk("b_vld", rd_vld, 1);
        chk("b_data", rd_data, {160'h0, 32'hC, 32'hB, 32'hA});
        chk("b_keep", rd_keep, 8'h07);
        chk("b_last", rd_last, 1);
        drain(1, 10);
        chk("b_burst_off", burst_rdy, 0);
        chk("b_used0", rd_used, 0);

        // Burst threshold: 15 words, then 16, then pop one
        for (int w = 0; w < 15; w++)
            for (int l = 0; l < 8; l++) push(32'h100 + 32'(w * 8 + l), 1'b0);
        step(); step();
        chk("c_used15", rd_used, 15);
        chk("c_burst15", burst_rdy, 0);
        for (int l = 0; l < 8; l++) push(32'h200 + 32'(l), 1'b0);
        step();
        chk("c_used16", rd_used, 16);
        chk("c_burst16", burst_rdy, 1);
        drain(1, 10);
        chk("c_used_pop", rd_used, 15);
        chk("c_burst_pop", burst_rdy, 0);
        drain(15, 100);
        chk("c_empty", rd_vld, 0);

        // Fill to capacity, overflow, drain in order
        n_stall = 0;
        for (int i = 0; i < 4096; i++) push(32'hC000_0000 | 32'(i), 1'b0);
        chk("d_no_stall", n_stall, 0);
        chk("d_wr_vld_low", wr_vld, 0);
        step();
        chk("d_used_full", rd_used, 512);
        push(32'hDEAD_BEEF, 1'b0);
        chk("d_ovf", overflow, 1);
        chk("d_used_keep", rd_used, 512);
        drain(512, 2000);
        chk("d_empty", rd_vld, 0);
        chk("d_q_empty", exp_q.size(), 0);
        chk("d_ovf_sticky", overflow, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("d_clr_ovf", overflow, 0);
        chk("d_clr_wr_vld", wr_vld, 0);
        step();
        chk("d_wr_vld_back", wr_vld, 1);

        // Streaming with wrap: write and read concurrently
        n_stall = 0;
        fork
            begin
                for (int i = 0; i < 16000; i++) push($urandom, 1'b0);
            end
            begin
                drain(2000, 20000);
            end
        join
        chk("e_no_stall", n_stall, 0);
        chk("e_ovf", overflow, 0);
        chk("e_used0", rd_used, 0);
        chk("e_q_empty", exp_q.size(), 0);

        // Reset mid-frame (lane 5) and mid-read
        for (int i = 0; i < 8; i++) push(32'h5500 + 32'(i), 1'b0);
        step(); step(); step();
        chk("f_pre_vld", rd_vld, 1);
        for (int i = 0; i < 5; i++) push(32'h6600 + 32'(i), 1'b0);
        rd_en = 1'b1;
        rst = 1'b1;
        #1;
        chk("f_rst_vld", rd_vld, 0);
        chk("f_rst_used", rd_used, 0);
        chk("f_rst_wr_vld", wr_vld, 0);
        chk("f_rst_burst", burst_rdy, 0);
        chk("f_rst_data", rd_data, 0);
        chk("f_rst_keep", rd_keep, 0);
        step();
        rst = 1'b0;
        rd_en = 1'b0;
        model_reset();
        step();
        chk("f_wr_vld", wr_vld, 1);
        push(32'hE1, 1'b0);
        push(32'hE2, 1'b0);
        push(32'hE3, 1'b1);
        step(); step();
        chk("f_vld", rd_vld, 1);
        chk("f_data", rd_data, {160'h0, 32'hE3, 32'hE2, 32'hE1});
        chk("f_keep", rd_keep, 8'h07);
        chk("f_last", rd_last, 1);
        drain(1, 10);
        chk("f_empty", rd_vld, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ddr_wr_pack_fifo.md
Name: ddr_wr_pack_fifo

Overview:
- Single-clock, parametrised width-packing prefetch FIFO for the DDR write path.
- Packs IN_WIDTH capture words into OUT_WIDTH DDR words. Presents them first-word-fall-through to the DDR write master.
- Adds frame-end flush with lane masks and a burst-ready indication, so the master issues whole bursts.
- Sits after the clock-domain crossing, in the DDR controller clock domain.

Parameters:
- IN_WIDTH, 32, input word width.
- OUT_WIDTH, 256, output word width. Must be an integer multiple of IN_WIDTH; RATIO = OUT_WIDTH/IN_WIDTH, RATIO >= 2.
- DEPTH_WIDTH, 9, log2 of wide-word storage depth (DEPTH = 2^DEPTH_WIDTH).
- BURST_LEN, 16, wide words per DDR burst. Range 1..DEPTH.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush, same effect as rst.
- wr_en  in  1  write strobe.
- wr_data  in  IN_WIDTH  narrow input word.
- wr_last  in  1  qualifies wr_en; marks the last word of a frame.
- wr_vld  out  1  space available; a write is accepted when wr_en && wr_vld.
- rd_en  in  1  pop strobe; honoured only when rd_vld.
- rd_vld  out  1  rd_data/rd_keep/rd_last are valid.
- rd_data  out  OUT_WIDTH  packed word.
- rd_keep  out  RATIO  per-lane valid mask.
- rd_last  out  1  word closes a frame.
- burst_rdy  out  1  master may start a burst.
- rd_used  out  DEPTH_WIDTH+1  committed wide words, including the output register.
- overflow  out  1  sticky: a write was attempted while wr_vld was low.

Behaviour:
- Reset (rst, async) and clear (sync, next edge): all outputs and counters go to 0, pointers go to 0, and the partial pack register is discarded. wr_vld rises the cycle after reset release.
- Packing:
  - Lane counter runs 0..RATIO-1.
  - An accepted word goes to lane bits [lane*IN_WIDTH +: IN_WIDTH]. Lane 0 is the LSBs, and the first word lands in the LSBs.
  - Commit fires on an accept when lane == RATIO-1 or wr_last == 1.
  - On commit, the packed word is written to RAM with all unused lanes zero.
  - The stored keep mask has bits 0..lane set. The stored last bit equals wr_last.
  - The lane counter returns to 0 after a commit.
- Capacity:
  - wr_vld = (rd_used + pending_commit) < DEPTH, registered.
  - A non-completing accept never blocks.
  - A write while wr_vld is low is dropped and sets overflow. overflow is cleared only by rst or clear.
- Latency:
  - Commit at edge k into an empty FIFO gives rd_vld = 1 after edge k+2 (RAM read plus prefetch register).
  - rd_used increments after edge k+1.
- Read:
  - rd_en && rd_vld pops at the edge; the next word is presented after the same edge if it is available (zero-bubble streaming).
  - rd_en while rd_vld is low is ignored, with no state change.
  - rd_data holds while rd_vld is high and rd_en is low.
- Simultaneous commit and pop: rd_used is unchanged and the pointers both advance.
- Pointers: binary, DEPTH_WIDTH+1 bits. Wrap-around is natural; full/empty is decided by comparing the MSBs.
- burst_rdy = (rd_used >= BURST_LEN) || (last_cnt != 0), registered.
  - last_cnt counts committed words with last == 1 that have not yet been popped.
  - Result: a frame tail shorter than a burst still drains.
- Assertions:
  - OUT_WIDTH % IN_WIDTH == 0.
  - BURST_LEN <= DEPTH.
  - rd_used <= DEPTH at all times.

Decomposition:
- Package ddr_fifo_pkg holds:
  - clog2 function.
  - RATIO and LANE_W derivation helpers.
  - Keep-mask width rule.
- Sub-module ddr_fifo_sdp_ram:
  - Simple dual-port, registered read.
  - Width OUT_WIDTH + RATIO + 1 (data, keep, last).
  - Depth 2^DEPTH_WIDTH.
  - Infers DRM.
- Top level holds the pack register, lane counter, pointers, prefetch register, counters and flags.

Test Plan:
- Default params, 8 back-to-back writes 0x1..0x8, no wr_last -> one word 0x00000008_..._00000001 with rd_keep = 0xFF and rd_last = 0, rd_vld 2 cycles after the 8th accept.
- 3 writes 0xA,0xB,0xC, the last with wr_last -> rd_data = {160'h0, 32'hC, 32'hB, 32'hA}, rd_keep = 0x07, rd_last = 1, burst_rdy = 1 while rd_used = 1.
- Fill 512 wide words with rd_en = 0 -> wr_vld falls after the 4096th accept and rd_used = 512. A further write sets overflow and is not stored; a drain returns exactly 512 words in order.
- Continuous write plus rd_en held high over 2000 wide words (pointer wrap) -> data in order, no gaps after the first word, rd_used stable.
- 15 full words committed -> burst_rdy = 0. The 16th -> burst_rdy = 1. Popping one -> burst_rdy = 0.
- rst asserted mid-frame (lane 5) and mid-read -> all outputs 0 immediately; the first post-reset word packs from lane 0 and no stale data appears.
